femul_arbiter: RTL
==================

# femul_arbiter

Shares the single pipelined field multiplier (255-bit mod 2^255−19, latency 2k = 34 cycles, one new operand pair every k = 17 cycles) between N independent requesters, e.g. a ladder sequencer and a separate inversion engine. It sits between the requesters and the multiplier's start/ready/done ports, grants issue slots round-robin, and records which requester owns each in-flight product. Each result is routed back to its owner.

## Interface
Parameters:
- N, 2: number of requesters (2..4).
- W, 255: field element width.
- MUL_LAT, 34: multiplier start-to-done latency in cycles; sets the post-reset drain window.
- TAG_DEPTH, 4: maximum products in flight (tag FIFO depth, power of two).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  requester i asks for a product; held high with operands stable until grant[i].
- req_a, req_b  in  N*W  operand pairs; slice i belongs to requester i.
- grant  out  N  one-cycle one-hot pulse; the operands of that requester are captured this cycle.
- rsp_valid  out  N  one-cycle one-hot pulse; rsp_data is valid for that requester.
- rsp_data  out  W  product routed to the owning requester.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  W  registered operands to the multiplier.
- mul_ready  in  1  multiplier can accept a start this cycle.
- mul_done  in  1  multiplier result pulse.
- mul_out  in  W  multiplier result.
- busy  out  1  tag FIFO non-empty or drain window active.
- err_orphan  out  1  sticky: mul_done arrived with no owning tag.

## Operation
- States: DRAIN → RUN.
  - Reset enters DRAIN with counter = MUL_LAT + 1.
  - DRAIN: no grants are issued and mul_done is ignored. It absorbs products left over from before reset, because the multiplier has no reset.
  - The counter decrements each cycle; the state moves to RUN when it reaches 0.
- Issue condition in RUN, per cycle: some req[i] = 1, mul_ready = 1, mul_start register = 0 (no back-to-back starts), and tag FIFO not full.
- Arbitration: round-robin. Search starts at last_grant+1 mod N. On a grant, last_grant is updated to the winner. Reset value of last_grant is N−1, so requester 0 wins first.
- On issue, all in the same clock edge:
  - grant[i] ← 1
  - mul_start ← 1
  - mul_a/mul_b ← req_a/req_b slice i
  - push i into the tag FIFO
- On mul_done in RUN with the FIFO non-empty: pop the head tag t, then rsp_valid ← one-hot(t) and rsp_data ← mul_out. Responses return in issue order because the multiplier is in-order.
- mul_done with an empty FIFO in RUN: drop the product and set err_orphan. Only reset clears err_orphan.
- Simultaneous push and pop: both take effect and the count is unchanged. A push is permitted when the FIFO is full only if a pop occurs in the same cycle.
- Responses cannot be back-pressured. A requester must take rsp_valid in the cycle it arrives.
- A requester may re-assert req in the cycle after its grant, for a new operand pair.
- Reset mid-operation:
  - The FIFO is cleared and in-flight products are discarded.
  - All outputs go to their reset values.
  - DRAIN is re-entered.
- Reset values: grant = 0, rsp_valid = 0, rsp_data = 0, mul_start = 0, mul_a = mul_b = 0, busy = 1 (DRAIN), err_orphan = 0.

## Timing
- All outputs are registered.
- req seen at edge t with the issue condition true: grant and mul_start are high during cycle t+1.
- Grant-to-response: mul_done at cycle d gives rsp_valid during cycle d+1. The nominal figure is MUL_LAT + 1 cycles from mul_start.
- Issue rate is at most one start per 2 cycles from the arbiter itself; in practice it is bounded by mul_ready (every 17 cycles).
- grant is deasserted the cycle after the pulse. mul_start is never high for two consecutive cycles.
- DRAIN lasts exactly MUL_LAT + 1 cycles after reset release. The first grant is possible on the following cycle.

## Structure
- Shared package curve25519_pkg holds:
  - FE_WIDTH = 255
  - MUL_K = 17
  - MUL_LAT = 2*MUL_K
  - P = 2^255 − 19
- The requester index tag type is $clog2(N) bits and stays local to this block.
- Sub-module tag_fifo: synchronous FIFO, width $clog2(N), depth TAG_DEPTH. It provides push, pop, full, empty and head, with asynchronous reset. It is the natural split.
- Everything else, the arbiter plus the DRAIN counter, stays in femul_arbiter.

## Test plan
- Reset release, req[0] high with a=2, b=3, against a behavioural femul model (latency 34, interval 17):
  - no grant for 35 cycles;
  - then grant[0] and mul_start;
  - rsp_valid[0] with rsp_data = 6, 35 cycles after mul_start.
- req[0] and req[1] held continuously, operands (5,7) and (11,13):
  - grants alternate 0, 1, 0, 1, spaced 17 cycles;
  - responses 35 and 143, each to the correct requester, in order.
- Model held at ready = 1 with latency 200, all requesters pending:
  - exactly 4 grants, then stall with FIFO full;
  - the 5th grant occurs in the same cycle as the first mul_done pop.
- Inject a spurious mul_done in RUN with an empty FIFO:
  - no rsp_valid;
  - err_orphan rises and stays 1 until reset.
- Assert reset 10 cycles after a grant, release after 3 cycles:
  - the old product arriving inside DRAIN produces no rsp_valid and no err_orphan;
  - the next request is served normally after the drain window.
- Operands a = P−1, b = P−1 → rsp_data = 1.

Source files
------------

// File: rtl/curve25519_pkg.sv
// curve25519_pkg: shared field constants and multiplier-arbiter state encoding
package curve25519_pkg;
  localparam int FE_WIDTH = 255;
  localparam int MUL_K = 17;
  localparam int MUL_LAT = 2 * MUL_K;
  localparam logic [FE_WIDTH-1:0] P = ~FE_WIDTH'(18);
  typedef enum logic {DRAIN, RUN} arb_state_t;
endpackage

// File: rtl/femul_arbiter_tag_fifo.sv
// tag_fifo: synchronous FIFO of requester tags for products in flight in the multiplier
module tag_fifo #(
  parameter int TW = 1,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [TW-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rd];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= push ? wr + 1'b1 : wr;
      rd <= pop ? rd + 1'b1 : rd;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clock)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/femul_arbiter.sv
// femul_arbiter: round-robin sharing of one pipelined field multiplier among N requesters
module femul_arbiter #(
  parameter int N = 2,
  parameter int W = curve25519_pkg::FE_WIDTH,
  parameter int MUL_LAT = curve25519_pkg::MUL_LAT,
  parameter int TAG_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_ready,
  input  logic           mul_done,
  input  logic [W-1:0]   mul_out,
  output logic           busy,
  output logic           err_orphan
);
  import curve25519_pkg::*;
  localparam int TW = $clog2(N);
  localparam int CW = $clog2(MUL_LAT + 2);
  arb_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] last, win, idx, head;
  logic found, issue, pop, orphan, full, empty;
  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= DRAIN;
      cnt <= CW'(MUL_LAT + 1);
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = (state == DRAIN && cnt == CW'(1)) ? RUN : state;
    cnt_n = (state == DRAIN) ? cnt - 1'b1 : cnt;
  end
  always_comb begin
    found = 1'b0;
    win = last;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = TW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    pop = state == RUN && mul_done && !empty;
    orphan = state == RUN && mul_done && empty;
    issue = state == RUN && found && mul_ready && !mul_start && (!full || pop);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      grant <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      mul_start <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      err_orphan <= 1'b0;
      last <= TW'(N - 1);
    end else begin
      grant <= issue ? N'(1) << win : '0;
      mul_start <= issue;
      mul_a <= issue ? a_arr[win] : mul_a;
      mul_b <= issue ? b_arr[win] : mul_b;
      last <= issue ? win : last;
      rsp_valid <= pop ? N'(1) << head : '0;
      rsp_data <= pop ? mul_out : rsp_data;
      err_orphan <= err_orphan | orphan;
    end
  assign busy = state == DRAIN || !empty;
  tag_fifo #(.TW(TW), .DEPTH(TAG_DEPTH)) u_tags (
    .clock(clock),
    .reset(reset),
    .push(issue),
    .pop(pop),
    .din(win),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule
